// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller.
package snake_pkg;

  localparam int unsigned XW      = 7;
  localparam int unsigned YW      = 6;
  localparam int unsigned MAX_LEN = 15;
  localparam int unsigned LEN_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // One-hot {stop,up,left,down,right}; the low four bits line up with key.
  localparam logic [4:0] DIR_STOP  = 5'b10000;
  localparam logic [4:0] DIR_UP    = 5'b01000;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_DOWN  = 5'b00010;
  localparam logic [4:0] DIR_RIGHT = 5'b00001;

  function automatic logic [4:0] dir_reverse(input logic [4:0] d);
    return {d[4], d[1], d[0], d[3], d[2]};
  endfunction

endpackage

// File: rtl/snake_tick.sv
// Step-period tick counter: counts while enabled, wrap_o marks the last cycle.
module snake_tick #(
  parameter int unsigned STEP_PERIOD = 15165696
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o
);

  localparam int unsigned CW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_ctrl.sv
// Snake game controller: run/pause FSM, direction arbitration, collision and scoring.
// Define SNAKE_SELF_HIT_EN to make the head hitting its own tail end the game.
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned STEP_PERIOD = 15165696,
  parameter int unsigned GRID_W      = 64,
  parameter int unsigned GRID_H      = 48,
  parameter int unsigned INIT_LEN    = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    pause,
  input  logic [3:0]              key,
  input  logic [XW-1:0]           head_x,
  input  logic [YW-1:0]           head_y,
  input  logic [MAX_LEN*XW-1:0]   tail_x,
  input  logic [MAX_LEN*YW-1:0]   tail_y,
  input  logic [XW-1:0]           food_x,
  input  logic [YW-1:0]           food_y,
  output logic                    step,
  output logic [4:0]              dir,
  output logic                    move_clr,
  output logic                    food_eaten,
  output logic [LEN_W-1:0]        length,
  output logic [7:0]              score,
  output logic [1:0]              state,
  output logic                    game_over
);

  localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);

  state_e           state_q, state_d;
  logic [4:0]       dir_q, dir_d, pend_q, pend_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       score_q, score_d;
  logic             clr_q, clr_d;
  logic             tick, start_ok, key_ok;
  logic [XW-1:0]    nx;
  logic [YW-1:0]    ny;
  logic             wall_hit, self_hit;

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_OVER);
  assign key_ok   = $onehot(key) && ({1'b0, key} != dir_reverse(dir_q));

  snake_tick #(.STEP_PERIOD(STEP_PERIOD)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (state_q == ST_RUN),
    .clr_i   (start_ok),
    .wrap_o  (tick)
  );

  always_comb begin
    nx       = head_x;
    ny       = head_y;
    wall_hit = 1'b0;
    case (pend_q)
      DIR_RIGHT: begin nx = head_x + 1'b1; wall_hit = (head_x == X_LAST); end
      DIR_LEFT:  begin nx = head_x - 1'b1; wall_hit = (head_x == '0);     end
      DIR_DOWN:  begin ny = head_y + 1'b1; wall_hit = (head_y == Y_LAST); end
      DIR_UP:    begin ny = head_y - 1'b1; wall_hit = (head_y == '0);     end
      default: ;
    endcase
  end

`ifdef SNAKE_SELF_HIT_EN
  always_comb begin
    self_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len_q) && nx == tail_x[i*XW +: XW] && ny == tail_y[i*YW +: YW]) begin
        self_hit = 1'b1;
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ^{tail_x, tail_y};
  assign self_hit    = 1'b0;
`endif

  // step/dir/food_eaten are decided in the tick cycle itself so the datapath
  // sees the committed direction together with the strobe.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    len_d      = len_q;
    score_d    = score_q;
    clr_d      = 1'b0;
    step       = 1'b0;
    food_eaten = 1'b0;
    dir        = DIR_STOP;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_ok) begin
          state_d = ST_RUN;
          dir_d   = DIR_RIGHT;
          pend_d  = DIR_RIGHT;
          len_d   = LEN_W'(INIT_LEN);
          score_d = '0;
          clr_d   = 1'b1;
        end
      end
      ST_RUN: begin
        dir = dir_q;
        if (key_ok) pend_d = {1'b0, key};
        if (pause)  state_d = ST_PAUSE;
        if (tick) begin
          dir_d = pend_q;
          if (wall_hit || self_hit) begin
            state_d = ST_OVER;
            dir     = DIR_STOP;
          end else begin
            step = 1'b1;
            dir  = pend_q;
            if (nx == food_x && ny == food_y) begin
              food_eaten = 1'b1;
              if (score_q != '1) score_d = score_q + 1'b1;
              if (len_q != LEN_W'(MAX_LEN)) len_d = len_q + 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (key_ok) pend_d = {1'b0, key};
        if (pause)  state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_RIGHT;
      pend_q  <= DIR_RIGHT;
      len_q   <= '0;
      score_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      score_q <= score_d;
      clr_q   <= clr_d;
    end
  end

  assign move_clr  = clr_q;
  assign length    = len_q;
  assign score     = score_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_OVER);

endmodule
